// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> 2N-bit quotient, N-bit remainder.
// One quotient bit per cycle, start/busy/done handshake, one operation in flight.
module seq_divider #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2*N-1:0]   dividend_i,
    input  logic [N-1:0]     divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2*N-1:0]   quotient_o,
    output logic [N-1:0]     remainder_o,
    output logic             dbz_o
);

    localparam int unsigned QW = 2 * N;
    localparam int unsigned CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   shreg_q, shreg_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            zdiv_q, zdiv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [N-1:0]    remo_q, remo_d;
    logic            dbz_q, dbz_d;

    logic [N:0]      r_shift;
    logic [N:0]      trial;
    logic [QW-1:0]   shreg_next;
    logic [N-1:0]    rem_next;

    // One restoring step: shift in the next dividend bit, try to subtract the divisor.
    always_comb begin
        r_shift    = {rem_q, shreg_q[QW-1]};
        trial      = r_shift - {1'b0, dvs_q};
        shreg_next = {shreg_q[QW-2:0], ~trial[N]};
        rem_next   = trial[N] ? r_shift[N-1:0] : trial[N-1:0];
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        zdiv_d  = zdiv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shreg_d = dividend_i;
                    dvs_d   = divisor_i;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                    if (divisor_i == '0) begin
                        zdiv_d = 1'b1;
                    end else begin
                        zdiv_d = 1'b0;
                        dbz_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (zdiv_q) begin
                    // Zero divisor resolves in a single cycle with a saturated quotient.
                    quo_d   = '1;
                    remo_d  = shreg_q[N-1:0];
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    zdiv_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    shreg_d = shreg_next;
                    rem_d   = rem_next;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(QW - 1)) begin
                        quo_d   = shreg_next;
                        remo_d  = rem_next;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            zdiv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            zdiv_q  <= zdiv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quo_q;
    assign remainder_o = remo_q;
    assign dbz_o       = dbz_q;

endmodule
